// File: rtl/vga_plot_arbiter_if.sv
// vga_plot_arbiter_if
// Bundles the requester-side pixel handshake, the clear request/status and
// the adapter write port of vga_plot_arbiter.
//   req[3:0], last[3:0]  : per-requester pixel valid / final pixel of burst
//   req_x[31:0]          : requester i x in bits [8i+7:8i]
//   req_y[27:0]          : requester i y in bits [7i+6:7i]
//   req_colour[11:0]     : requester i colour in bits [3i+2:3i]
//   gnt[3:0], ack[3:0]   : one-hot owner (registered) / pixel accepted (comb.)
//   clear_req, clear_busy: clear pulse in, clear pending-or-running out
//   x, y, colour, plot   : registered write port toward vga_adapter
// modport master: the requester/datapath side; modport slave: the arbiter.
interface vga_plot_arbiter_if;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        clear_req;
  logic        clear_busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  modport master (
    output req, last, req_x, req_y, req_colour, clear_req,
    input  gnt, ack, clear_busy, x, y, colour, plot
  );

  modport slave (
    input  req, last, req_x, req_y, req_colour, clear_req,
    output gnt, ack, clear_busy, x, y, colour, plot
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
// Shares the single pixel-write port of the 160x120 VGA adapter between four
// drawing requesters. Bursts are granted round-robin; each pixel is accepted
// with ack and appears on the write port one cycle later with plot=1. A clear
// sequencer sweeps the whole frame with CLEAR_COLOUR after reset or on request.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : vga_plot_arbiter_if.slave (requests, clear, adapter write port)
module vga_plot_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_plot_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  localparam logic [7:0] X_LAST = 8'd159;
  localparam logic [6:0] Y_LAST = 7'd119;

  state_t      state_r;
  logic [7:0]  cx_r;
  logic [6:0]  cy_r;
  logic [1:0]  ptr_r;
  logic [1:0]  owner_r;
  logic [3:0]  gnt_r;
  logic        plot_r;
  logic [7:0]  x_r;
  logic [6:0]  y_r;
  logic [2:0]  colour_r;
  logic        clear_busy_r;
  logic        pending_r;

  logic [1:0]  sel_s;
  logic        found_s;
  logic [3:0]  ack_s;
  logic        own_req_s;
  logic        own_last_s;
  logic [7:0]  own_x_s;
  logic [6:0]  own_y_s;
  logic [2:0]  own_c_s;

  // Round-robin pick: first requesting index scanning upward from ptr_r, wrapping.
  always_comb begin
    sel_s   = ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && bus.req[ptr_r + 2'(k)]) begin
        sel_s   = ptr_r + 2'(k);
        found_s = 1'b1;
      end else begin
        sel_s   = sel_s;
      end
    end
  end

  // Pixel fields of the current owner.
  always_comb begin
    own_x_s = 8'd0;
    own_y_s = 7'd0;
    own_c_s = 3'd0;
    case (owner_r)
      2'd0: begin
        own_x_s = bus.req_x[7:0];
        own_y_s = bus.req_y[6:0];
        own_c_s = bus.req_colour[2:0];
      end
      2'd1: begin
        own_x_s = bus.req_x[15:8];
        own_y_s = bus.req_y[13:7];
        own_c_s = bus.req_colour[5:3];
      end
      2'd2: begin
        own_x_s = bus.req_x[23:16];
        own_y_s = bus.req_y[20:14];
        own_c_s = bus.req_colour[8:6];
      end
      2'd3: begin
        own_x_s = bus.req_x[31:24];
        own_y_s = bus.req_y[27:21];
        own_c_s = bus.req_colour[11:9];
      end
      default: begin
        own_x_s = 8'd0;
        own_y_s = 7'd0;
        own_c_s = 3'd0;
      end
    endcase
  end

  assign own_req_s  = bus.req[owner_r];
  assign own_last_s = bus.last[owner_r];

  // Acknowledge is combinational so the owner can advance every cycle; it is
  // masked during reset because the state register may still read GRANT then.
  always_comb begin
    if (!reset && state_r == ST_GRANT) begin
      ack_s = gnt_r & bus.req;
    end else begin
      ack_s = 4'b0000;
    end
  end

  // Arbiter FSM, clear sweep counters and registered adapter write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_CLEAR;
      cx_r         <= 8'd0;
      cy_r         <= 7'd0;
      ptr_r        <= 2'd0;
      owner_r      <= 2'd0;
      gnt_r        <= 4'b0000;
      plot_r       <= 1'b0;
      x_r          <= 8'd0;
      y_r          <= 7'd0;
      colour_r     <= 3'd0;
      clear_busy_r <= 1'b1;
      pending_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          // One frame pixel per cycle, x inner; clear_req here is ignored.
          plot_r       <= 1'b1;
          x_r          <= cx_r;
          y_r          <= cy_r;
          colour_r     <= CLEAR_COLOUR;
          gnt_r        <= 4'b0000;
          clear_busy_r <= 1'b1;
          pending_r    <= 1'b0;
          if (cx_r == X_LAST) begin
            cx_r <= 8'd0;
            if (cy_r == Y_LAST) begin
              cy_r    <= 7'd0;
              state_r <= ST_IDLE;
            end else begin
              cy_r <= cy_r + 7'd1;
            end
          end else begin
            cx_r <= cx_r + 8'd1;
          end
        end

        ST_IDLE: begin
          plot_r <= 1'b0;
          if (pending_r || bus.clear_req) begin
            // A clear outranks every requester.
            state_r      <= ST_CLEAR;
            cx_r         <= 8'd0;
            cy_r         <= 7'd0;
            pending_r    <= 1'b0;
            clear_busy_r <= 1'b1;
            gnt_r        <= 4'b0000;
          end else if (|bus.req) begin
            gnt_r        <= 4'b0001 << sel_s;
            owner_r      <= sel_s;
            state_r      <= ST_GRANT;
            clear_busy_r <= 1'b0;
          end else begin
            gnt_r        <= 4'b0000;
            clear_busy_r <= 1'b0;
          end
        end

        ST_GRANT: begin
          // A clear request waits for the burst to finish.
          if (bus.clear_req) begin
            pending_r    <= 1'b1;
            clear_busy_r <= 1'b1;
          end else begin
            pending_r    <= pending_r;
          end
          if (own_req_s) begin
            plot_r   <= 1'b1;
            x_r      <= own_x_s;
            y_r      <= own_y_s;
            colour_r <= own_c_s;
            if (own_last_s) begin
              gnt_r   <= 4'b0000;
              ptr_r   <= owner_r + 2'd1;
              state_r <= ST_IDLE;
            end else begin
              gnt_r   <= gnt_r;
            end
          end else begin
            // Owner withdrew: release without accepting a pixel.
            plot_r  <= 1'b0;
            gnt_r   <= 4'b0000;
            ptr_r   <= owner_r + 2'd1;
            state_r <= ST_IDLE;
          end
        end

        default: begin
          state_r <= ST_CLEAR;
          cx_r    <= 8'd0;
          cy_r    <= 7'd0;
          gnt_r   <= 4'b0000;
          plot_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.ack        = ack_s;
  assign bus.clear_busy = clear_busy_r;
  assign bus.x          = x_r;
  assign bus.y          = y_r;
  assign bus.colour     = colour_r;
  assign bus.plot       = plot_r;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Testbench for vga_plot_arbiter. Each "round" is a set of requesters that
// all raise req together while the arbiter is idle; the reference model lays
// out the whole round as a timeline (cyclic service order from the pointer,
// burst lengths, bubbles, optional clear) and predicts every output per cycle.
module tb_vga_plot_arbiter;

  localparam int CLEAR_PIX = 19200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_plot_arbiter_if bus ();

  vga_plot_arbiter #(.NUM_REQ(4), .CLEAR_COLOUR(3'b000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Round description and model timeline.
  int ptr_m, next_ptr;
  bit in_set [4];
  int len [4];
  int drop [4];
  int g [4];
  int a [4];
  int occ [4];
  int px_x [4][8];
  int px_y [4][8];
  int px_c [4][8];
  int clr_owner = -1;
  int clr_at = -1;
  int rst_at = -1;
  int gap = 0;
  int i_c, i_last;

  logic [7:0] hold_x;
  logic [6:0] hold_y;
  logic [2:0] hold_c;
  bit         carry_v;
  logic [7:0] carry_x;
  logic [6:0] carry_y;
  logic [2:0] carry_c;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Lay out the round: service order is cyclic from the pointer.
  task automatic compute_round();
    int t, i;
    t = 1;
    i_c = -1;
    next_ptr = ptr_m;
    for (int k = 0; k < 4; k++) begin
      i = (ptr_m + k) % 4;
      if (in_set[i]) begin
        g[i] = t;
        a[i] = (drop[i] > 0) ? drop[i] : len[i];
        occ[i] = a[i] + ((drop[i] > 0) ? 1 : 0);
        t = t + occ[i] + 1;
        if (i == clr_owner) begin
          i_c = g[i] + occ[i];
          t = t + CLEAR_PIX + 1;
        end
        next_ptr = (i + 1) % 4;
      end else begin
        g[i] = -100;
        a[i] = 0;
        occ[i] = 0;
      end
    end
    i_last = t - 1;
  endtask

  task automatic drive_round(input int r);
    int j;
    for (int i = 0; i < 4; i++) begin
      j = 0;
      if (in_set[i] && r > g[i]) j = r - g[i];
      if (in_set[i] && j > len[i] - 1) j = len[i] - 1;
      bus.req[i] = in_set[i] && (r < g[i] + a[i]);
      bus.last[i] = in_set[i] && (j == len[i] - 1);
      bus.req_x[8*i +: 8] = 8'(px_x[i][j]);
      bus.req_y[7*i +: 7] = 7'(px_y[i][j]);
      bus.req_colour[3*i +: 3] = 3'(px_c[i][j]);
    end
    bus.clear_req = (r == clr_at);
  endtask

  task automatic run_round();
    logic [3:0] eg, ea;
    logic       ep;
    bit         eb;
    int         k;
    for (int r = 0; r < i_last + gap; r++) begin
      @(negedge clk);
      drive_round(r);
      if (r == rst_at) begin
        reset = 1'b1;
        #1;
        check_val("ack_in_reset", {28'd0, bus.ack}, 32'd0);
        break;
      end
      #1;
      eg = 4'b0000;
      ea = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (in_set[i] && r >= g[i] && r < g[i] + occ[i]) eg[i] = 1'b1;
        if (in_set[i] && r >= g[i] && r < g[i] + a[i]) ea[i] = 1'b1;
      end
      ep = carry_v;
      if (carry_v) begin
        hold_x = carry_x;
        hold_y = carry_y;
        hold_c = carry_c;
      end
      check_val($sformatf("round_r%0d", r),
                {5'd0, bus.gnt, bus.ack, bus.plot, bus.x, bus.y, bus.colour},
                {5'd0, eg, ea, ep, hold_x, hold_y, hold_c});
      if (r >= 1) begin
        eb = (clr_at >= 0) && (r > clr_at) && (r <= i_c + CLEAR_PIX + 1);
        check_val($sformatf("busy_r%0d", r), {31'd0, bus.clear_busy}, {31'd0, eb});
      end
      // Pixel issued this cycle shows on the port next cycle.
      carry_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (in_set[i] && r >= g[i] && r < g[i] + a[i]) begin
          carry_v = 1'b1;
          carry_x = 8'(px_x[i][r - g[i]]);
          carry_y = 7'(px_y[i][r - g[i]]);
          carry_c = 3'(px_c[i][r - g[i]]);
        end
      end
      if (i_c >= 0 && r >= i_c + 1 && r <= i_c + CLEAR_PIX) begin
        k = r - i_c - 1;
        carry_v = 1'b1;
        carry_x = 8'(k % 160);
        carry_y = 7'(k / 160);
        carry_c = 3'd0;
      end
    end
    ptr_m = next_ptr;
  endtask

  // Reset (nrst extra cycles), then check the full-frame sweep that follows.
  // Inputs are held at cycle 0 of the already computed next round.
  task automatic sweep_after_reset(input int nrst);
    int k;
    for (int n = 0; n < nrst; n++) begin
      @(negedge clk);
      reset = 1'b1;
      drive_round(0);
      #1;
      check_val("ack_in_reset", {28'd0, bus.ack}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_round(0);
    #1;
    hold_x = 8'd0;
    hold_y = 7'd0;
    hold_c = 3'd0;
    check_val("reset_state", {5'd0, bus.gnt, bus.ack, bus.plot, bus.x, bus.y, bus.colour}, 32'd0);
    check_val("reset_busy", {31'd0, bus.clear_busy}, 32'd1);
    for (int c = 1; c < CLEAR_PIX; c++) begin
      @(negedge clk);
      drive_round(0);
      #1;
      k = c - 1;
      check_val($sformatf("sweep_%0d", k),
                {5'd0, bus.gnt, bus.ack, bus.plot, bus.x, bus.y, bus.colour},
                {5'd0, 4'b0000, 4'b0000, 1'b1, 8'(k % 160), 7'(k / 160), 3'd0});
      check_val("sweep_busy", {31'd0, bus.clear_busy}, 32'd1);
    end
    carry_v = 1'b1;
    carry_x = 8'd159;
    carry_y = 7'd119;
    carry_c = 3'd0;
  endtask

  task automatic clear_round();
    for (int i = 0; i < 4; i++) begin
      in_set[i] = 1'b0;
      len[i] = 1;
      drop[i] = 0;
      for (int j = 0; j < 8; j++) begin
        px_x[i][j] = $urandom_range(0, 159);
        px_y[i][j] = $urandom_range(0, 119);
        px_c[i][j] = $urandom_range(0, 7);
      end
    end
    gap = 0;
    clr_owner = -1;
    clr_at = -1;
    rst_at = -1;
  endtask

  task automatic rand_round();
    clear_round();
    while (!(in_set[0] || in_set[1] || in_set[2] || in_set[3])) begin
      for (int i = 0; i < 4; i++) in_set[i] = ($urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 4; i++) begin
      len[i] = $urandom_range(1, 6);
      if (len[i] > 1 && $urandom_range(0, 3) == 0) drop[i] = $urandom_range(1, len[i] - 1);
    end
    gap = $urandom_range(0, 2);
  endtask

  initial begin
    bus.req = 4'b0000;
    bus.last = 4'b0000;
    bus.req_x = 32'd0;
    bus.req_y = 28'd0;
    bus.req_colour = 12'd0;
    bus.clear_req = 1'b0;
    carry_v = 1'b0;

    // Reset with all four requesting: sweep, then single-pixel bursts 0,1,2,3.
    ptr_m = 0;
    clear_round();
    for (int i = 0; i < 4; i++) in_set[i] = 1'b1;
    compute_round();
    sweep_after_reset(2);
    run_round();
    // Requester 0 again completes the order 0,1,2,3,0.
    clear_round();
    in_set[0] = 1'b1;
    compute_round();
    run_round();

    // Clear pulse during a 5-pixel burst of requester 1, requester 3 waiting.
    clear_round();
    in_set[1] = 1'b1;
    in_set[3] = 1'b1;
    len[1] = 5;
    len[3] = $urandom_range(1, 4);
    clr_owner = 1;
    compute_round();
    clr_at = g[1] + 2;
    run_round();

    // Requester 2 alone with a fixed 3-pixel burst.
    clear_round();
    in_set[2] = 1'b1;
    len[2] = 3;
    px_x[2][0] = 10; px_y[2][0] = 20; px_c[2][0] = 6;
    px_x[2][1] = 11; px_y[2][1] = 20; px_c[2][1] = 5;
    px_x[2][2] = 12; px_y[2][2] = 20; px_c[2][2] = 3;
    gap = 1;
    compute_round();
    run_round();

    // Owner 0 withdraws after 2 of 4 pixels, requester 1 waiting.
    clear_round();
    in_set[0] = 1'b1;
    in_set[1] = 1'b1;
    len[0] = 4;
    drop[0] = 2;
    len[1] = $urandom_range(1, 5);
    compute_round();
    run_round();

    // Randomized traffic.
    for (int n = 0; n < 30; n++) begin
      rand_round();
      compute_round();
      run_round();
    end

    // Reset on the 3rd pixel of a burst; the sweep restarts at (0,0).
    clear_round();
    in_set[1] = 1'b1;
    len[1] = 5;
    compute_round();
    rst_at = g[1] + 2;
    run_round();
    ptr_m = 0;
    rand_round();
    compute_round();
    sweep_after_reset(0);
    run_round();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
